mpsoc_wb_ext_arbiter: RTL and testbench

MPSOC_WB_EXT_ARBITER -- requirements
Module: mpsoc_wb_ext_arbiter

---
 rtl/mpsoc_wb_pkg.sv | 26 ++
 rtl/mpsoc_rr_select.sv | 28 ++
 rtl/mpsoc_wb_ext_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mpsoc_wb_ext_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_wb_pkg.sv
// Shared Wishbone definitions for the MPSoC external-port arbiter family:
// arbiter FSM states and Wishbone B3 cycle-type / burst-type encodings.
package mpsoc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERR   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Cycle type identifiers (CTI)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions (BTE)
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/mpsoc_rr_select.sv
// Combinational round-robin picker: scans requests starting just after the
// previous owner, wrapping at N-1, and returns a one-hot grant (zero if idle).
module mpsoc_rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_owner) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_wb_ext_arbiter.sv
// Round-robin arbiter giving NUM_MASTERS tile masters shared access to one
// external Wishbone port, with a stall watchdog that forces an error response.
module mpsoc_wb_ext_arbiter
  import mpsoc_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [DW-1:0]               m_dat_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  input  logic [DW-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, rr_gnt;
  logic [IW-1:0]          last_q, last_d, owner_idx;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic          owner_cyc, owner_stb, owner_we;
  logic [AW-1:0] owner_adr;
  logic [DW-1:0] owner_dat;
  logic [SW-1:0] owner_sel;
  logic [2:0]    owner_cti;
  logic [1:0]    owner_bte;
  logic          busy, any_resp, stalled, stall_hit;

  mpsoc_rr_select #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_select (
    .req        (m_cyc_i),
    .last_owner (last_q),
    .gnt        (rr_gnt)
  );

  // AND-OR mux of the owner's bus signals; grant_q is one-hot or zero.
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_dat = '0;
    owner_sel = '0;
    owner_cti = '0;
    owner_bte = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner_cyc |= m_cyc_i[i];
        owner_stb |= m_stb_i[i];
        owner_we  |= m_we_i[i];
        owner_adr |= m_adr_i[i*AW +: AW];
        owner_dat |= m_dat_i[i*DW +: DW];
        owner_sel |= m_sel_i[i*SW +: SW];
        owner_cti |= m_cti_i[i*3 +: 3];
        owner_bte |= m_bte_i[i*2 +: 2];
        owner_idx |= IW'(i);
      end
    end
  end

  // Handshake: a beat completes on any cycle where s_stb_o is high together
  // with one of s_ack_i/s_err_i/s_rty_i; stb high with no response is a stall.
  assign busy      = (state_q == ST_BUSY);
  assign any_resp  = s_ack_i | s_err_i | s_rty_i;
  assign stalled   = busy & owner_stb & ~any_resp;
  assign stall_hit = stalled & (stall_q == STALL_LIMIT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    stall_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = rr_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Watchdog wins over a simultaneous cyc drop so the error still issues.
        if (stall_hit) begin
          state_d = ST_ERR;
        end else if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end else if (stalled) begin
          stall_d = stall_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
    end
  end

  assign s_cyc_o = busy & owner_cyc;
  assign s_stb_o = busy & owner_stb;
  assign s_we_o  = busy & owner_we;
  assign s_adr_o = busy ? owner_adr : '0;
  assign s_dat_o = busy ? owner_dat : '0;
  assign s_sel_o = busy ? owner_sel : '0;
  assign s_cti_o = busy ? owner_cti : '0;
  assign s_bte_o = busy ? owner_bte : '0;

  assign m_ack_o = (busy && s_ack_i) ? grant_q : '0;
  assign m_rty_o = (busy && s_rty_i) ? grant_q : '0;
  assign m_err_o = ((busy && s_err_i) || (state_q == ST_ERR)) ? grant_q : '0;
  assign m_dat_o = s_dat_i;

  assign grant_o   = grant_q;
  assign timeout_o = (state_q == ST_ERR);

endmodule

// File: tb/tb_mpsoc_wb_ext_arbiter.sv
// Directed bench for mpsoc_wb_ext_arbiter: transaction-level ownership model
// checked every cycle, plus hand-computed expectations at key points.
module tb_mpsoc_wb_ext_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat = '0;
  logic [N*SW-1:0]   m_sel = '0;
  logic [N*3-1:0]    m_cti = '0;
  logic [N*2-1:0]    m_bte = '0;
  logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [DW-1:0]     s_dat = '0;

  logic [N-1:0]  m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [DW-1:0] m_dat_o, s_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;

  mpsoc_wb_ext_arbiter #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_cti_i   (m_cti),
    .m_bte_i   (m_bte),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .m_dat_o   (m_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .s_rty_i   (s_rty),
    .s_dat_i   (s_dat),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // ---------------- ownership model ----------------
  // mode: 0 = nobody owns, 1 = owner transferring, 2 = error beat, 3 = waiting for owner release
  int  md_mode  = 0;
  int  md_owner = 0;
  int  md_last  = N - 1;
  int  md_stall = 0;
  bit  model_valid = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int pick;
    pick = -1;
    for (int k = 1; k <= N; k++)
      if (pick < 0 && req[(last + k) % N]) pick = (last + k) % N;
    return pick;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      md_mode = 0; md_last = N - 1; md_owner = 0; md_stall = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      case (md_mode)
        0: if (m_cyc != 0) begin
             md_owner = rr_pick(m_cyc, md_last);
             md_mode  = 1;
             md_stall = 0;
           end
        1: begin
             if (m_stb[md_owner] && !(s_ack || s_err || s_rty)) md_stall++;
             else md_stall = 0;
             if (md_stall >= TO) begin
               md_mode = 2; md_stall = 0;
             end else if (!m_cyc[md_owner]) begin
               md_mode = 0; md_last = md_owner; md_stall = 0;
             end
           end
        2: md_mode = 3;
        default: if (!m_cyc[md_owner]) begin
                   md_mode = 0; md_last = md_owner;
                 end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0]  e_grant, e_ack, e_err, e_rty;
  logic          e_busy;
  always @(negedge clk) begin
    if (model_valid) begin
      e_busy  = (md_mode == 1);
      e_grant = (md_mode == 0) ? '0 : N'(1) << md_owner;
      e_ack   = (e_busy && s_ack) ? e_grant : '0;
      e_rty   = (e_busy && s_rty) ? e_grant : '0;
      e_err   = ((e_busy && s_err) || md_mode == 2) ? e_grant : '0;
      chk("cyc_grant", grant_o, e_grant);
      chk("cyc_s_cyc", s_cyc_o, e_busy ? m_cyc[md_owner] : 1'b0);
      chk("cyc_s_stb", s_stb_o, e_busy ? m_stb[md_owner] : 1'b0);
      chk("cyc_s_we",  s_we_o,  e_busy ? m_we[md_owner]  : 1'b0);
      chk("cyc_s_adr", s_adr_o, e_busy ? m_adr[md_owner*AW +: AW] : '0);
      chk("cyc_s_dat", s_dat_o, e_busy ? m_dat[md_owner*DW +: DW] : '0);
      chk("cyc_s_sel", s_sel_o, e_busy ? m_sel[md_owner*SW +: SW] : '0);
      chk("cyc_s_cti", s_cti_o, e_busy ? m_cti[md_owner*3 +: 3] : '0);
      chk("cyc_s_bte", s_bte_o, e_busy ? m_bte[md_owner*2 +: 2] : '0);
      chk("cyc_m_ack", m_ack_o, e_ack);
      chk("cyc_m_err", m_err_o, e_err);
      chk("cyc_m_rty", m_rty_o, e_rty);
      chk("cyc_m_dat", m_dat_o, s_dat);
      chk("cyc_timeout", timeout_o, md_mode == 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clk);
  endtask

  task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
    m_sel[i*SW +: SW] = sel;
    m_cti[i*3 +: 3]   = cti;
    m_bte[i*2 +: 2]   = bte;
  endtask

  task automatic drop_m(input int i);
    drive_m(i, 1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 2'b00);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    chk("model_rr_first",  rr_pick(4'b0101, 3), 0);
    chk("model_rr_wrap",   rr_pick(4'b0011, 1), 0);

    // reset state
    repeat (3) step();
    at_mid();
    chk("reset_grant", grant_o, 4'b0000);
    chk("reset_s_cyc", s_cyc_o, 1'b0);
    chk("reset_timeout", timeout_o, 1'b0);

    // m0 and m2 request together; m0 wins first, then m2 after one idle cycle
    step();
    rst = 1'b1;
    drive_m(0, 1, 0, 0, 32'h0000_1000, '0, 4'hF, 3'b000, 2'b00);
    drive_m(2, 1, 0, 0, 32'h0000_2000, '0, 4'hF, 3'b000, 2'b00);
    at_mid();
    chk("idle_before_edge", grant_o, 4'b0000);
    step();
    at_mid();
    chk("first_grant", grant_o, 4'b0001);
    chk("arb_latency_cyc", s_cyc_o, 1'b1);
    step();
    drive_m(0, 1, 1, 0, 32'h0000_1004, '0, 4'hF, 3'b000, 2'b00);
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    at_mid();
    chk("m0_ack", m_ack_o, 4'b0001);
    chk("m0_adr", s_adr_o, 32'h0000_1004);
    step();
    drop_m(0);
    s_ack = 1'b0;
    at_mid();
    chk("hold_until_drop", grant_o, 4'b0001);
    step();
    at_mid();
    chk("idle_gap", grant_o, 4'b0000);
    step();
    at_mid();
    chk("rr_m2", grant_o, 4'b0100);

    // m2 4-beat incrementing burst while m1 waits
    step();
    drive_m(1, 1, 0, 0, 32'h0000_3000, '0, 4'hF, 3'b000, 2'b00);
    for (int b = 0; b < 4; b++) begin
      drive_m(2, 1, 1, 0, 32'h0000_2000 + 32'(b * 4), '0, 4'hF,
              (b < 3) ? 3'b010 : 3'b111, 2'b00);
      s_ack = 1'b1; s_dat = 32'hA000_0000 + 32'(b);
      at_mid();
      chk("burst_grant", grant_o, 4'b0100);
      chk("burst_ack", m_ack_o, 4'b0100);
      step();
    end
    drop_m(2);
    s_ack = 1'b0;
    at_mid();
    chk("burst_hold_grant", grant_o, 4'b0100);
    step();
    at_mid();
    chk("burst_idle", grant_o, 4'b0000);
    step();
    at_mid();
    chk("m1_after_burst", grant_o, 4'b0010);

    // m1 write
    step();
    drive_m(1, 1, 1, 1, 32'h0000_3010, 32'hCAFE_0001, 4'b0011, 3'b000, 2'b01);
    s_ack = 1'b1;
    at_mid();
    chk("m1_we", s_we_o, 1'b1);
    chk("m1_wdata", s_dat_o, 32'hCAFE_0001);
    chk("m1_sel", s_sel_o, 4'b0011);
    chk("m1_bte", s_bte_o, 2'b01);
    chk("m1_ack", m_ack_o, 4'b0010);
    step();
    drop_m(1);
    s_ack = 1'b0;
    step();

    // m3 read with DEADBEEF, then a retry
    drive_m(3, 1, 1, 0, 32'h0000_4000, '0, 4'hF, 3'b000, 2'b00);
    at_mid();
    chk("m3_wait_idle", grant_o, 4'b0000);
    step();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    at_mid();
    chk("m3_grant", grant_o, 4'b1000);
    chk("m3_ack", m_ack_o, 4'b1000);
    chk("m3_rdata", m_dat_o, 32'hDEAD_BEEF);
    chk("m3_no_err", m_err_o, 4'b0000);
    step();
    s_ack = 1'b0; s_rty = 1'b1;
    at_mid();
    chk("m3_rty", m_rty_o, 4'b1000);
    chk("m3_rty_no_ack", m_ack_o, 4'b0000);
    step();
    s_rty = 1'b0;
    drop_m(3);
    step();

    // watchdog: m0 stalls, m1 waits
    drive_m(0, 1, 1, 0, 32'h0000_5000, '0, 4'hF, 3'b000, 2'b00);
    drive_m(1, 1, 0, 0, 32'h0000_6000, '0, 4'hF, 3'b000, 2'b00);
    step();
    repeat (7) step();
    at_mid();
    chk("pre_timeout_grant", grant_o, 4'b0001);
    chk("pre_timeout_pulse", timeout_o, 1'b0);
    chk("pre_timeout_cyc", s_cyc_o, 1'b1);
    step();
    at_mid();
    chk("timeout_err", m_err_o, 4'b0001);
    chk("timeout_pulse", timeout_o, 1'b1);
    chk("timeout_cyc_low", s_cyc_o, 1'b0);
    chk("timeout_stb_low", s_stb_o, 1'b0);
    step();
    at_mid();
    chk("drain_pulse_gone", timeout_o, 1'b0);
    chk("drain_no_err", m_err_o, 4'b0000);
    chk("drain_grant", grant_o, 4'b0001);
    chk("drain_cyc_low", s_cyc_o, 1'b0);
    step();
    drop_m(0);
    step();
    at_mid();
    chk("drain_exit_idle", grant_o, 4'b0000);
    step();
    at_mid();
    chk("post_timeout_next", grant_o, 4'b0010);

    // owner drops cyc on the very cycle the watchdog expires
    step();
    drive_m(1, 1, 1, 0, 32'h0000_6004, '0, 4'hF, 3'b000, 2'b00);
    repeat (7) step();
    drive_m(1, 0, 1, 0, 32'h0000_6004, '0, 4'hF, 3'b000, 2'b00);
    at_mid();
    chk("late_drop_cyc", s_cyc_o, 1'b0);
    step();
    at_mid();
    chk("late_drop_pulse", timeout_o, 1'b1);
    chk("late_drop_err", m_err_o, 4'b0010);
    step();
    drop_m(1);
    at_mid();
    chk("late_drop_drain", grant_o, 4'b0010);
    step();
    at_mid();
    chk("late_drop_exit", grant_o, 4'b0000);

    // reset while m2 is busy with stb high
    step();
    drive_m(2, 1, 1, 0, 32'h0000_7000, '0, 4'hF, 3'b000, 2'b00);
    drive_m(0, 1, 0, 0, 32'h0000_8000, '0, 4'hF, 3'b000, 2'b00);
    step();
    at_mid();
    chk("pre_reset_grant", grant_o, 4'b0100);
    chk("pre_reset_stb", s_stb_o, 1'b1);
    step();
    rst = 1'b0;
    at_mid();
    chk("reset_not_yet", grant_o, 4'b0100);
    step();
    s_ack = 1'b1;
    at_mid();
    chk("reset_mid_cyc", s_cyc_o, 1'b0);
    chk("reset_mid_grant", grant_o, 4'b0000);
    chk("reset_mid_no_ack", m_ack_o, 4'b0000);
    step();
    rst = 1'b1;
    s_ack = 1'b0;
    at_mid();
    chk("reset_release_idle", grant_o, 4'b0000);
    step();
    at_mid();
    chk("post_reset_m0", grant_o, 4'b0001);

    step();
    drop_m(0);
    drop_m(2);
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
